// File: rtl/fetch_unit.sv
// Program-counter / instruction-fetch sequencer with a halt/step run-control FSM.
// Optional return-address stack enabled by defining FETCH_UNIT_RAS_EN.
module fetch_unit #(
    parameter int              PC_W      = 16,
    parameter int              OFF_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         Init_n,
    input  logic                         Start,
    input  logic                         Halt,
    input  logic                         Run,
    input  logic                         Step,
    input  logic                         Branch_rel,
    input  logic                         ALU_zero,
    input  logic [OFF_W-1:0]             Offset,
    input  logic                         Jump_abs,
    input  logic                         Call,
    input  logic                         Ret,
    input  logic [PC_W-1:0]              Target,
    output logic [PC_W-1:0]              PC,
    output logic                         Halted,
    output logic [$clog2(RAS_DEPTH):0]   Ras_count,
    output logic                         Ras_ovf,
    output logic                         Ras_udf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t          r_state, w_state_next;
    logic [PC_W-1:0] r_pc, w_pc_next;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_off_ext;
    logic            w_push, w_pop, w_clear;
    logic            w_ovf_set, w_udf_set;
    logic [PC_W-1:0] w_ras_top;
    logic [CNT_W-1:0] w_ras_cnt;

    assign w_pc_inc  = r_pc + 1'b1;
    assign w_off_ext = PC_W'($signed(Offset));

    always_ff @(posedge clk or negedge Init_n) begin
        if (!Init_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = w_pc_inc;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_clear      = 1'b0;
        w_ovf_set    = 1'b0;
        w_udf_set    = 1'b0;
        if (Start) begin
            w_state_next = ST_RUN;
            w_pc_next    = RESET_PC;
            w_clear      = 1'b1;
        end else if (Halt) begin
            w_state_next = ST_HALTED;
            w_pc_next    = r_pc;
        end else if (r_state == ST_HALTED) begin
            if (Run) begin
                w_state_next = ST_RUN;
            end
            w_pc_next = Step ? w_pc_inc : r_pc;
        end else if (Ret) begin
`ifdef FETCH_UNIT_RAS_EN
            // An empty stack falls through to sequential fetch.
            if (w_ras_cnt != '0) begin
                w_pc_next = w_ras_top;
                w_pop     = 1'b1;
            end else begin
                w_udf_set = 1'b1;
            end
`endif
        end else if (Call) begin
            w_pc_next = Target;
`ifdef FETCH_UNIT_RAS_EN
            w_push    = 1'b1;
            w_ovf_set = (w_ras_cnt == CNT_W'(RAS_DEPTH));
`endif
        end else if (Jump_abs) begin
            w_pc_next = Target;
        end else if (Branch_rel && ALU_zero) begin
            w_pc_next = r_pc + w_off_ext;
        end
    end

`ifdef FETCH_UNIT_RAS_EN
    logic [PC_W-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf, r_udf;
    logic [PTR_W-1:0] w_top_idx;

    assign w_top_idx = r_wp - 1'b1;
    assign w_ras_top = r_ras[w_top_idx];
    assign w_ras_cnt = r_cnt;

    // Circular storage: when full, the write slot is the oldest entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[r_wp] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk or negedge Init_n) begin
        if (!Init_n) begin
            r_wp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (w_clear) begin
            r_wp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
                if (r_cnt != CNT_W'(RAS_DEPTH)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_pop) begin
                r_wp  <= w_top_idx;
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_udf_set) r_udf <= 1'b1;
        end
    end

    assign Ras_count = r_cnt;
    assign Ras_ovf   = r_ovf;
    assign Ras_udf   = r_udf;
`else
    assign w_ras_top = '0;
    assign w_ras_cnt = '0;
    assign Ras_count = '0;
    assign Ras_ovf   = 1'b0;
    assign Ras_udf   = 1'b0;
`endif

    assign PC     = r_pc;
    assign Halted = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; RAS checks compile in when FETCH_UNIT_RAS_EN is defined.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        Init_n;
    logic        Start, Halt, Run, Step;
    logic        Branch_rel, ALU_zero, Jump_abs, Call, Ret;
    logic [7:0]  Offset;
    logic [15:0] Target;
    logic [15:0] PC;
    logic        Halted;
    logic [2:0]  Ras_count;
    logic        Ras_ovf, Ras_udf;

    int n_total = 0;
    int n_bad   = 0;

    fetch_unit dut (
        .clk(clk), .Init_n(Init_n), .Start(Start), .Halt(Halt), .Run(Run),
        .Step(Step), .Branch_rel(Branch_rel), .ALU_zero(ALU_zero),
        .Offset(Offset), .Jump_abs(Jump_abs), .Call(Call), .Ret(Ret),
        .Target(Target), .PC(PC), .Halted(Halted), .Ras_count(Ras_count),
        .Ras_ovf(Ras_ovf), .Ras_udf(Ras_udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic idle_inputs();
        Start = 0; Halt = 0; Run = 0; Step = 0; Branch_rel = 0; ALU_zero = 0;
        Jump_abs = 0; Call = 0; Ret = 0; Offset = 8'h00; Target = 16'h0000;
    endtask

    // One active edge, then sample 1 time unit later; inputs return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic jump_to(input logic [15:0] t);
        Jump_abs = 1; Target = t;
        tick();
    endtask

    initial begin
        idle_inputs();
        Init_n = 0;
        #12;
        chk("rst_pc", PC, 16'd0);
        chk("rst_halted", Halted, 0);
        chk("rst_cnt", Ras_count, 0);
        chk("rst_ovf", Ras_ovf, 0);
        chk("rst_udf", Ras_udf, 0);
        @(negedge clk);
        Init_n = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("seq_pc%0d", i), PC, i);
        end

        // Relative branches
        jump_to(16'd10);
        chk("jump10", PC, 16'd10);
        Branch_rel = 1; ALU_zero = 1; Offset = 8'hFC;
        tick();
        chk("br_taken_neg", PC, 16'd6);
        jump_to(16'd10);
        Branch_rel = 1; ALU_zero = 0; Offset = 8'hFC;
        tick();
        chk("br_not_taken", PC, 16'd11);
        jump_to(16'h0010);
        Branch_rel = 1; ALU_zero = 1; Offset = 8'h7F;
        tick();
        chk("br_pos_max", PC, 16'h008F);
        jump_to(16'd2);
        Branch_rel = 1; ALU_zero = 1; Offset = 8'hFC;
        tick();
        chk("br_wrap_low", PC, 16'hFFFE);
        jump_to(16'hFFFF);
        tick();
        chk("inc_wrap", PC, 16'h0000);

        // Jump beats branch
        Jump_abs = 1; Target = 16'h1234; Branch_rel = 1; ALU_zero = 1; Offset = 8'h04;
        tick();
        chk("jump_over_br", PC, 16'h1234);

        // Halt / step / run
        jump_to(16'd20);
        Halt = 1;
        tick();
        chk("halt_pc", PC, 16'd20);
        chk("halt_flag", Halted, 1);
        for (int i = 0; i < 2; i++) begin
            Branch_rel = 1; ALU_zero = 1; Offset = 8'h05; Call = 1; Target = 16'h0300; Jump_abs = 1;
            tick();
            chk($sformatf("halted_ignore%0d", i), PC, 16'd20);
        end
        Step = 1;
        tick();
        chk("step_pc", PC, 16'd21);
        chk("step_still_halted", Halted, 1);
        Run = 1;
        tick();
        chk("run_pc", PC, 16'd21);
        chk("run_flag", Halted, 0);
        tick();
        chk("after_run_pc", PC, 16'd22);
        Step = 1;
        tick();
        chk("step_in_run", PC, 16'd23);
        Halt = 1;
        tick();
        Run = 1; Halt = 1;
        tick();
        chk("run_with_halt", Halted, 1);
        Start = 1; Halt = 1;
        tick();
        chk("start_over_halt_pc", PC, 16'd0);
        chk("start_over_halt_flag", Halted, 0);

`ifdef FETCH_UNIT_RAS_EN
        jump_to(16'd5);
        Call = 1; Target = 16'd100;
        tick();
        chk("call1_pc", PC, 16'd100);
        chk("call1_cnt", Ras_count, 1);
        Call = 1; Target = 16'd200;
        tick();
        chk("call2_pc", PC, 16'd200);
        chk("call2_cnt", Ras_count, 2);
        Ret = 1; Call = 1; Target = 16'h0777;
        tick();
        chk("ret1_pc", PC, 16'd101);
        chk("ret1_cnt", Ras_count, 1);
        Ret = 1;
        tick();
        chk("ret2_pc", PC, 16'd6);
        chk("ret2_cnt", Ras_count, 0);
        Ret = 1;
        tick();
        chk("udf_pc", PC, 16'd7);
        chk("udf_flag", Ras_udf, 1);
        chk("udf_cnt", Ras_count, 0);
        Start = 1;
        tick();
        chk("start_clr_udf", Ras_udf, 0);
        for (int i = 1; i <= 5; i++) begin
            Call = 1; Target = 16'(i * 16'h0100);
            tick();
        end
        chk("ovf_flag", Ras_ovf, 1);
        chk("ovf_cnt", Ras_count, 4);
        for (int i = 4; i >= 1; i--) begin
            Ret = 1;
            tick();
            chk($sformatf("lifo_ret%0d", i), PC, 16'(i * 16'h0100 + 1));
        end
        chk("lifo_cnt", Ras_count, 0);
        chk("lifo_udf", Ras_udf, 0);
        Start = 1;
        tick();
        chk("start_clr_ovf", Ras_ovf, 0);
        Call = 1; Target = 16'h0040;
        tick();
        Halt = 1;
        tick();
        chk("halt_keeps_ras", Ras_count, 1);
`else
        jump_to(16'd3);
        Call = 1; Target = 16'd50;
        tick();
        chk("noras_call_pc", PC, 16'd50);
        chk("noras_call_cnt", Ras_count, 0);
        Ret = 1;
        tick();
        chk("noras_ret_pc", PC, 16'd51);
        chk("noras_ret_cnt", Ras_count, 0);
        chk("noras_udf", Ras_udf, 0);
        Call = 1; Target = 16'h0040;
        tick();
        Halt = 1;
        tick();
`endif

        // Asynchronous reset mid-cycle while halted
        chk("pre_rst_halted", Halted, 1);
        #2;
        Init_n = 0;
        #1;
        chk("arst_pc", PC, 16'd0);
        chk("arst_halted", Halted, 0);
        chk("arst_cnt", Ras_count, 0);
        #1;
        Init_n = 1;
        tick();
        chk("post_rst_pc", PC, 16'd1);
        Ret = 1;
        tick();
        chk("post_rst_ret_pc", PC, 16'd2);
        chk("post_rst_cnt", Ras_count, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
